tdm_voice_scheduler: RTL and testbench
======================================

Name: tdm_voice_scheduler

Overview:
- Per-sample-period sequencer for the 8-voice TDM sample pipeline.
- On each sample-rate tick it fetches one fix14_16 sample per voice from the voice engines, slot by slot (channel 0..7).
- It drives the pipeline's channel/data inputs, issues a flush slot, captures the summed u16 result at the exact pipeline latency, and hands it to the DAC/PWM output stage via valid/ready.

Parameters:
- NUM_VOICES, 8, voices per frame; power of two.
- NUM_VOICE_BITS, 3, log2(NUM_VOICES).
- D_W, 16, sample width.
- PIPE_LAT, 3, cycles from a slot driven on pipe_chan/pipe_data to its summed result on pipe_result (DAR register + summer + cast).
- IDLE_CHAN, 7, channel value driven on non-slot cycles; must be non-zero.

Ports:
- dsp_clk  in  1  sole clock.
- dsp_rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse that starts a frame.
- voice_mask  in  NUM_VOICES  bit v=1 means voice v is active; bit v=0 injects zero without a request.
- voice_req  out  1  request pulse to the voice engines.
- voice_idx  out  NUM_VOICE_BITS  voice being requested; held while waiting.
- voice_vld  in  1  voice_data valid; any latency of at least 1 cycle after voice_req.
- voice_data  in  D_W  fix14_16 sample.
- pipe_chan  out  NUM_VOICE_BITS  to pipeline channel_in.
- pipe_data  out  D_W  to pipeline data_in_fix14_16.
- pipe_result  in  D_W  pipeline data_out_u16.
- dac_data  out  D_W  captured u16 frame sample.
- dac_vld  out  1  dac_data valid.
- dac_rdy  in  1  downstream accept.
- busy  out  1  high from the accepted tick until capture.
- overrun  out  1  sticky; set on a missed tick or an overwritten unaccepted sample; cleared only by reset.

Behaviour:
- Reset values:
  - voice_req=0, voice_idx=0.
  - pipe_chan=IDLE_CHAN, pipe_data=0.
  - dac_data=0, dac_vld=0, busy=0, overrun=0.
  - State=IDLE, slot=0.
- All outputs are registered.
- Idle-cycle rule: on every cycle that is not a slot, drive pipe_chan=IDLE_CHAN and pipe_data=0. The summer adds zero, which keeps the accumulator intact; channel 0 is never driven outside a slot.
- IDLE:
  - sample_tick sets busy=1, slot=0.
  - Go to REQ if voice_mask[0]=1, else INJECT.
- REQ:
  - Pulse voice_req for exactly 1 cycle with voice_idx=slot, then go to WAIT.
- WAIT:
  - Hold voice_idx.
  - On voice_vld, drive the slot next cycle: pipe_chan=slot, pipe_data=voice_data. Go to NEXT.
- INJECT:
  - Drive the slot next cycle: pipe_chan=slot, pipe_data=0. No voice_req is issued. Go to NEXT.
- NEXT:
  - If slot=NUM_VOICES-1, go to FLUSH.
  - Else slot+1 (no wrap inside a frame) and go to REQ or INJECT according to the mask bit.
- FLUSH:
  - Drive one cycle of pipe_chan=0, pipe_data=0. The summer then emits the frame sum.
  - Load the drain counter with PIPE_LAT and go to DRAIN.
- DRAIN:
  - Count down.
  - At zero, capture pipe_result into dac_data, set dac_vld=1, busy=0, go to IDLE.
  - The capture cycle is exactly PIPE_LAT cycles after the FLUSH drive cycle.
- DAC handshake:
  - dac_vld stays high and dac_data stays stable until dac_vld&&dac_rdy; dac_vld clears the following cycle.
  - If a capture occurs while dac_vld=1 and dac_rdy=0: overwrite dac_data, keep dac_vld=1, set overrun.
  - If capture and acceptance fall in the same cycle, dac_vld stays 1 with the new data, and overrun is not set.
- sample_tick while busy: the tick is dropped, overrun is set, and the current frame continues unchanged.
- sample_tick coinciding with capture: the tick counts as busy and is dropped.
- voice_vld outside WAIT: ignored.
- voice_mask: sampled per slot at the point of decision.
- dsp_rst mid-frame: return to reset values on the next edge. The pipeline accumulator is not cleared; the first frame after reset yields a correct sum because slot 0 overwrites the accumulator.

Optional Feature:
- Macro: TDM_OVERRUN_COUNT_EN.
- Defined:
  - Adds output overrun_cnt[7:0], a saturating count of overrun events.
  - Adds input overrun_clr, which clears both overrun and overrun_cnt synchronously.
  - If overrun_clr coincides with an event, the clear wins.
- Undefined: neither port exists; overrun is sticky until reset.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, REQ, WAIT, INJECT, NEXT, FLUSH, DRAIN);
  - NUM_VOICES, NUM_VOICE_BITS and D_W;
  - the PIPE_LAT default of 3, shared with the pipeline top.
- One natural sub-module, tdm_dac_output_holder: the dac_data/dac_vld register with its overwrite/overrun logic.

Test Plan:
- Full frame:
  - Stimulus: mask=8'hFF, every voice returns 16'h0100 one cycle after its request, then one tick.
  - Required: 8 requests with idx 0..7; pipe_chan sequence 0..7 then flush 0; dac_data=16'h80FF (sum 0x800>>3=0x100, plus 0x7FFF); dac_vld rises PIPE_LAT cycles after flush.
- Masked voices:
  - Stimulus: mask=8'h01, voice 0 returns 16'h0800.
  - Required: exactly 1 voice_req; dac_data=16'h80FF.
- Negative sum:
  - Stimulus: mask=8'hFF, all voices return 16'hFF00.
  - Required: dac_data=16'h7EFE.
- Slow voice:
  - Stimulus: voice 3 asserts voice_vld 20 cycles late.
  - Required: pipe_chan=IDLE_CHAN with data 0 during the wait; result identical to the Full frame scenario.
- Overruns:
  - Stimulus: a second tick arrives mid-frame, and dac_rdy=0 across two frames.
  - Required: tick dropped; overrun=1; dac_data holds the newest sample; with TDM_OVERRUN_COUNT_EN, overrun_cnt=2.
- Reset mid-frame:
  - Stimulus: dsp_rst in WAIT, then a new frame with mask=8'hFF and all voices returning 16'h0100.
  - Required: all outputs take their reset values on the next edge; the following frame yields dac_data=16'h80FF.

Source files
------------

// File: rtl/tdm_voice_scheduler_pkg.sv
// tdm_voice_scheduler_pkg
// Shared constants and the state encoding for the TDM voice scheduler.
// PIPE_LAT is the DAR register + summer + cast latency. The sample pipeline
// top shares this constant.
package tdm_voice_scheduler_pkg;

   localparam int NUM_VOICES     = 8;
   localparam int NUM_VOICE_BITS = 3;
   localparam int D_W            = 16;
   localparam int PIPE_LAT       = 3;
   localparam int DRAIN_W        = $clog2(PIPE_LAT + 1);

   // Channel parked on the pipeline between slots. It must be non-zero,
   // because channel 0 restarts the accumulator.
   localparam logic [NUM_VOICE_BITS-1:0] IDLE_CHAN = NUM_VOICE_BITS'(7);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_INJECT = 3'd3,
      ST_NEXT   = 3'd4,
      ST_FLUSH  = 3'd5,
      ST_DRAIN  = 3'd6
   } state_t;

endpackage

// File: rtl/tdm_voice_scheduler_dac.sv
// tdm_dac_output_holder
// Holds the captured frame sample for the DAC/PWM stage with a valid/ready
// handshake.
// Ports:
//   dsp_clk, dsp_rst : clock and synchronous active-high reset
//   capture          : load cap_data this cycle
//   cap_data         : summed u16 frame sample from the pipeline
//   dac_rdy          : downstream accept
//   dac_data/dac_vld : registered output sample and its valid flag
//   overwrite        : one-cycle pulse; a capture replaced a sample that was
//                      still unaccepted
module tdm_dac_output_holder
   import tdm_voice_scheduler_pkg::*;
(
   input  logic           dsp_clk,
   input  logic           dsp_rst,
   input  logic           capture,
   input  logic [D_W-1:0] cap_data,
   input  logic           dac_rdy,
   output logic [D_W-1:0] dac_data,
   output logic           dac_vld,
   output logic           overwrite
);

   logic [D_W-1:0] dac_data_reg, dac_data_next;
   logic           dac_vld_reg, dac_vld_next;

   always_comb begin
      dac_data_next = dac_data_reg;
      dac_vld_next  = dac_vld_reg;
      overwrite     = 1'b0;
      if (capture) begin
         // A capture always leaves valid high. If the old sample is also
         // being accepted this cycle, nothing is lost.
         dac_data_next = cap_data;
         dac_vld_next  = 1'b1;
         overwrite     = dac_vld_reg && !dac_rdy;
      end else if (dac_vld_reg && dac_rdy) begin
         dac_vld_next = 1'b0;
      end
   end

   always_ff @(posedge dsp_clk) begin
      if (dsp_rst) begin
         dac_data_reg <= '0;
         dac_vld_reg  <= 1'b0;
      end else begin
         dac_data_reg <= dac_data_next;
         dac_vld_reg  <= dac_vld_next;
      end
   end

   assign dac_data = dac_data_reg;
   assign dac_vld  = dac_vld_reg;

endmodule

// File: rtl/tdm_voice_scheduler.sv
// tdm_voice_scheduler
// Sequencer for one sample period of the 8-voice TDM pipeline. On each
// sample_tick it fetches one sample per voice (slots 0..7) and drives each
// slot onto pipe_chan/pipe_data. It then drives a flush slot and captures the
// summed result exactly PIPE_LAT cycles later into the DAC output holder.
// Ports:
//   dsp_clk, dsp_rst       : clock and synchronous active-high reset
//   sample_tick            : starts a frame
//   voice_mask             : active-voice mask; inactive voices inject zero
//   voice_req/voice_idx    : request to the voice engines
//   voice_vld/voice_data   : voice engine response
//   pipe_chan/pipe_data    : pipeline slot inputs
//   pipe_result            : pipeline summed output
//   dac_data/dac_vld/dac_rdy : output handshake
//   busy                   : a frame is in progress
//   overrun                : sticky; a tick was missed or a sample was
//                            overwritten
// Optional feature (macro TDM_OVERRUN_COUNT_EN):
//   overrun_clr            : clears overrun and overrun_cnt
//   overrun_cnt            : saturating count of overrun events
// All outputs are registered.
module tdm_voice_scheduler
   import tdm_voice_scheduler_pkg::*;
(
   input  logic                      dsp_clk,
   input  logic                      dsp_rst,
   input  logic                      sample_tick,
   input  logic [NUM_VOICES-1:0]     voice_mask,
   output logic                      voice_req,
   output logic [NUM_VOICE_BITS-1:0] voice_idx,
   input  logic                      voice_vld,
   input  logic [D_W-1:0]            voice_data,
   output logic [NUM_VOICE_BITS-1:0] pipe_chan,
   output logic [D_W-1:0]            pipe_data,
   input  logic [D_W-1:0]            pipe_result,
   output logic [D_W-1:0]            dac_data,
   output logic                      dac_vld,
   input  logic                      dac_rdy,
   output logic                      busy,
   output logic                      overrun
`ifdef TDM_OVERRUN_COUNT_EN
   ,
   input  logic                      overrun_clr,
   output logic [7:0]                overrun_cnt
`endif
);

   state_t                    state_reg, state_next;
   logic [NUM_VOICE_BITS-1:0] slot_reg, slot_next;
   logic [DRAIN_W-1:0]        drain_reg, drain_next;
   logic                      voice_req_reg, voice_req_next;
   logic [NUM_VOICE_BITS-1:0] voice_idx_reg, voice_idx_next;
   logic [NUM_VOICE_BITS-1:0] pipe_chan_reg, pipe_chan_next;
   logic [D_W-1:0]            pipe_data_reg, pipe_data_next;
   logic                      busy_reg, busy_next;
   logic                      overrun_reg, overrun_next;
   logic                      capture;
   logic                      tick_drop;
   logic                      overwrite;

   // A tick is dropped whenever a frame is in progress. This includes the
   // capture cycle, because busy_reg is still high then.
   assign tick_drop = sample_tick && busy_reg;

   always_comb begin
      state_next     = state_reg;
      slot_next      = slot_reg;
      drain_next     = drain_reg;
      voice_req_next = 1'b0;
      voice_idx_next = voice_idx_reg;
      // Non-slot cycles park the pipeline on IDLE_CHAN with zero data, so the
      // accumulator adds nothing.
      pipe_chan_next = IDLE_CHAN;
      pipe_data_next = '0;
      busy_next      = busy_reg;
      capture        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (sample_tick) begin
               busy_next  = 1'b1;
               slot_next  = '0;
               state_next = voice_mask[0] ? ST_REQ : ST_INJECT;
            end
         end
         ST_REQ: begin
            voice_req_next = 1'b1;
            voice_idx_next = slot_reg;
            state_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (voice_vld) begin
               pipe_chan_next = slot_reg;
               pipe_data_next = voice_data;
               state_next     = ST_NEXT;
            end
         end
         ST_INJECT: begin
            pipe_chan_next = slot_reg;
            state_next     = ST_NEXT;
         end
         ST_NEXT: begin
            if (slot_reg == NUM_VOICE_BITS'(NUM_VOICES - 1)) begin
               state_next = ST_FLUSH;
            end else begin
               slot_next  = slot_reg + NUM_VOICE_BITS'(1);
               state_next = voice_mask[slot_next] ? ST_REQ : ST_INJECT;
            end
         end
         ST_FLUSH: begin
            // Channel 0 with zero data makes the summer emit the frame sum.
            pipe_chan_next = '0;
            drain_next     = DRAIN_W'(PIPE_LAT);
            state_next     = ST_DRAIN;
         end
         ST_DRAIN: begin
            // The counter reaches zero in the cycle that is PIPE_LAT cycles
            // after the flush drive cycle. pipe_result holds the sum then.
            if (drain_reg == '0) begin
               capture    = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end else begin
               drain_next = drain_reg - DRAIN_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef TDM_OVERRUN_COUNT_EN
   logic [7:0] overrun_cnt_reg, overrun_cnt_next;
   logic [8:0] cnt_sum;

   always_comb begin
      cnt_sum = {1'b0, overrun_cnt_reg} + 9'(tick_drop) + 9'(overwrite);
      overrun_cnt_next = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      overrun_next     = overrun_reg | tick_drop | overwrite;
      if (overrun_clr) begin
         overrun_cnt_next = '0;
         overrun_next     = 1'b0;
      end
   end

   always_ff @(posedge dsp_clk) begin
      if (dsp_rst) overrun_cnt_reg <= '0;
      else         overrun_cnt_reg <= overrun_cnt_next;
   end

   assign overrun_cnt = overrun_cnt_reg;
`else
   always_comb overrun_next = overrun_reg | tick_drop | overwrite;
`endif

   always_ff @(posedge dsp_clk) begin
      if (dsp_rst) begin
         state_reg     <= ST_IDLE;
         slot_reg      <= '0;
         drain_reg     <= '0;
         voice_req_reg <= 1'b0;
         voice_idx_reg <= '0;
         pipe_chan_reg <= IDLE_CHAN;
         pipe_data_reg <= '0;
         busy_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         slot_reg      <= slot_next;
         drain_reg     <= drain_next;
         voice_req_reg <= voice_req_next;
         voice_idx_reg <= voice_idx_next;
         pipe_chan_reg <= pipe_chan_next;
         pipe_data_reg <= pipe_data_next;
         busy_reg      <= busy_next;
         overrun_reg   <= overrun_next;
      end
   end

   tdm_dac_output_holder u_dac (
      .dsp_clk   (dsp_clk),
      .dsp_rst   (dsp_rst),
      .capture   (capture),
      .cap_data  (pipe_result),
      .dac_rdy   (dac_rdy),
      .dac_data  (dac_data),
      .dac_vld   (dac_vld),
      .overwrite (overwrite)
   );

   assign voice_req = voice_req_reg;
   assign voice_idx = voice_idx_reg;
   assign pipe_chan = pipe_chan_reg;
   assign pipe_data = pipe_data_reg;
   assign busy      = busy_reg;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// tb_tdm_voice_scheduler
// Directed bench for tdm_voice_scheduler. The bench models the voice engines
// and the 3-stage sample pipeline (DAR register, summer, u16 cast). It runs
// the full-frame, masked, negative, slow-voice, overrun and reset scenarios.
// Define TDM_OVERRUN_COUNT_EN when building to include the overrun counter
// ports.
module tb_tdm_voice_scheduler;
   import tdm_voice_scheduler_pkg::*;

   logic                      dsp_clk = 1'b0;
   logic                      dsp_rst;
   logic                      sample_tick;
   logic [NUM_VOICES-1:0]     voice_mask;
   logic                      voice_req;
   logic [NUM_VOICE_BITS-1:0] voice_idx;
   logic                      voice_vld;
   logic [D_W-1:0]            voice_data;
   logic [NUM_VOICE_BITS-1:0] pipe_chan;
   logic [D_W-1:0]            pipe_data;
   logic [D_W-1:0]            pipe_result = '0;
   logic [D_W-1:0]            dac_data;
   logic                      dac_vld;
   logic                      dac_rdy;
   logic                      busy;
   logic                      overrun;
`ifdef TDM_OVERRUN_COUNT_EN
   logic                      overrun_clr;
   logic [7:0]                overrun_cnt;
`endif

   int n_checks = 0;
   int errors   = 0;

   always #5 dsp_clk = ~dsp_clk;

   tdm_voice_scheduler dut (
      .dsp_clk     (dsp_clk),
      .dsp_rst     (dsp_rst),
      .sample_tick (sample_tick),
      .voice_mask  (voice_mask),
      .voice_req   (voice_req),
      .voice_idx   (voice_idx),
      .voice_vld   (voice_vld),
      .voice_data  (voice_data),
      .pipe_chan   (pipe_chan),
      .pipe_data   (pipe_data),
      .pipe_result (pipe_result),
      .dac_data    (dac_data),
      .dac_vld     (dac_vld),
      .dac_rdy     (dac_rdy),
      .busy        (busy),
      .overrun     (overrun)
`ifdef TDM_OVERRUN_COUNT_EN
      ,
      .overrun_clr (overrun_clr),
      .overrun_cnt (overrun_cnt)
`endif
   );

   // Pipeline model. Channel 0 emits the running sum and restarts the
   // accumulator with its own data. The cast divides by 8 and offsets by
   // 0x7FFF. Negative sums land one LSB lower, so -256 gives 0x7EFE.
   logic [NUM_VOICE_BITS-1:0] dar_chan = '0;
   logic [D_W-1:0]            dar_data = '0;
   logic signed [D_W-1:0]     acc      = '0;
   logic signed [D_W-1:0]     sum_out  = '0;

   function automatic logic [D_W-1:0] cast_u16(input logic signed [D_W-1:0] s);
      logic signed [D_W-1:0] x;
      x = s >>> 3;
      return D_W'(x) + 16'h7FFF - ((x < 0) ? 16'd1 : 16'd0);
   endfunction

   always @(posedge dsp_clk) begin
      dar_chan <= pipe_chan;
      dar_data <= pipe_data;
      if (dar_chan == '0) begin
         sum_out <= acc;
         acc     <= dar_data;
      end else begin
         acc <= acc + dar_data;
      end
      pipe_result <= cast_u16(sum_out);
   end

   // Voice engine model: answers a request after resp_delay cycles.
   logic [D_W-1:0] voice_val [NUM_VOICES];
   int             resp_delay [NUM_VOICES];

   initial begin
      int idx;
      voice_vld  = 1'b0;
      voice_data = '0;
      forever begin
         @(negedge dsp_clk);
         if (voice_req === 1'b1) begin
            idx = int'(voice_idx);
            repeat (resp_delay[idx]) @(negedge dsp_clk);
            voice_vld  = 1'b1;
            voice_data = voice_val[idx];
            @(negedge dsp_clk);
            voice_vld  = 1'b0;
            voice_data = '0;
         end
      end
   end

   // Activity log, sampled mid-cycle.
   int cyc = 0;
   int req_cnt;
   int req_idx [$];
   int chan_seq [$];
   int flush_cyc;
   int rise_cyc;
   logic prev_vld = 1'b0;

   initial begin
      forever begin
         @(negedge dsp_clk);
         cyc++;
         if (voice_req === 1'b1) begin
            req_cnt++;
            req_idx.push_back(int'(voice_idx));
         end
         if (!(pipe_chan === IDLE_CHAN && pipe_data === '0))
            chan_seq.push_back(int'(pipe_chan));
         if (pipe_chan === '0 && pipe_data === '0) flush_cyc = cyc;
         if (dac_vld === 1'b1 && prev_vld !== 1'b1) rise_cyc = cyc;
         prev_vld = dac_vld;
      end
   end

   task automatic clear_log();
      req_cnt   = 0;
      req_idx.delete();
      chan_seq.delete();
      flush_cyc = -1;
      rise_cyc  = -1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge dsp_clk);
         #1;
      end
   endtask

   task automatic set_voices(input logic [D_W-1:0] v, input int d);
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_val[i]  = v;
         resp_delay[i] = d;
      end
   endtask

   task automatic tick();
      @(negedge dsp_clk); #1;
      sample_tick = 1'b1;
      @(negedge dsp_clk); #1;
      sample_tick = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 400) begin
         @(negedge dsp_clk); #1;
         n++;
         if (busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic wait_req(input int idx, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge dsp_clk); #1;
         n++;
         if (voice_req === 1'b1 && int'(voice_idx) == idx) ok = 1'b1;
      end
   endtask

   // Reset state of every output packed together: voice_req, voice_idx,
   // pipe_chan, pipe_data, dac_data, dac_vld, busy, overrun.
   localparam logic [41:0] RESET_VEC = {1'b0, 3'd0, 3'd7, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0};

   task automatic test_reset();
      dsp_rst = 1'b1;
      cycles(3);
      n_checks++;
      if ({voice_req, voice_idx, pipe_chan, pipe_data, dac_data, dac_vld, busy, overrun} !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h",
                  {voice_req, voice_idx, pipe_chan, pipe_data, dac_data, dac_vld, busy, overrun}, RESET_VEC);
      end
`ifdef TDM_OVERRUN_COUNT_EN
      n_checks++;
      if (overrun_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", overrun_cnt);
      end
`endif
      dsp_rst = 1'b0;
      cycles(2);
      $display("test_reset done");
   endtask

   task automatic test_full_frame();
      bit ok;
      bit bad;
      int exp_chan [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      set_voices(16'h0100, 1);
      voice_mask = 8'hFF;
      clear_log();
      tick();
      wait_done(ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL full_done: busy stuck at %b expected 0", busy); end
      n_checks++;
      if (dac_data !== 16'h80FF) begin errors++; $display("FAIL full_data: got %h expected 80ff", dac_data); end
      n_checks++;
      if (dac_vld !== 1'b1) begin errors++; $display("FAIL full_vld: got %b expected 1", dac_vld); end
      n_checks++;
      if (req_cnt != 8) begin errors++; $display("FAIL full_req_cnt: got %0d expected 8", req_cnt); end
      bad = (req_idx.size() != 8);
      for (int i = 0; i < req_idx.size() && i < 8; i++) if (req_idx[i] != i) bad = 1'b1;
      n_checks++;
      if (bad) begin errors++; $display("FAIL full_req_idx: got %p expected 0..7", req_idx); end
      bad = (chan_seq.size() != 9);
      for (int i = 0; i < chan_seq.size() && i < 9; i++) if (chan_seq[i] != exp_chan[i]) bad = 1'b1;
      n_checks++;
      if (bad) begin errors++; $display("FAIL full_chan_seq: got %p expected %p", chan_seq, exp_chan); end
      // Capture falls in cycle flush+PIPE_LAT. The registered valid is seen
      // one cycle later.
      n_checks++;
      if (rise_cyc - flush_cyc != PIPE_LAT + 1) begin
         errors++;
         $display("FAIL full_latency: got %0d expected %0d", rise_cyc - flush_cyc, PIPE_LAT + 1);
      end
      cycles(1);
      n_checks++;
      if (dac_vld !== 1'b0) begin errors++; $display("FAIL full_vld_clear: got %b expected 0", dac_vld); end
      $display("test_full_frame done: dac_data=%h", dac_data);
   endtask

   task automatic test_masked();
      bit ok;
      set_voices(16'h0000, 1);
      voice_val[0] = 16'h0800;
      voice_mask   = 8'h01;
      clear_log();
      tick();
      wait_done(ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL masked_done: busy stuck at %b expected 0", busy); end
      n_checks++;
      if (req_cnt != 1) begin errors++; $display("FAIL masked_req_cnt: got %0d expected 1", req_cnt); end
      n_checks++;
      if (dac_data !== 16'h80FF) begin errors++; $display("FAIL masked_data: got %h expected 80ff", dac_data); end
      cycles(2);
      $display("test_masked done: dac_data=%h", dac_data);
   endtask

   task automatic test_negative();
      bit ok;
      set_voices(16'hFF00, 1);
      voice_mask = 8'hFF;
      clear_log();
      tick();
      wait_done(ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL neg_done: busy stuck at %b expected 0", busy); end
      n_checks++;
      if (dac_data !== 16'h7EFE) begin errors++; $display("FAIL neg_data: got %h expected 7efe", dac_data); end
      cycles(2);
      $display("test_negative done: dac_data=%h", dac_data);
   endtask

   task automatic test_slow_voice();
      bit ok;
      bit bad;
      set_voices(16'h0100, 1);
      resp_delay[3] = 20;
      voice_mask = 8'hFF;
      clear_log();
      tick();
      wait_req(3, ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL slow_req3: got no request expected idx 3"); end
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cycles(1);
         if (pipe_chan !== IDLE_CHAN || pipe_data !== '0 || voice_idx !== 3'd3) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin errors++; $display("FAIL slow_idle: got chan %0d data %h expected chan 7 data 0", pipe_chan, pipe_data); end
      wait_done(ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL slow_done: busy stuck at %b expected 0", busy); end
      n_checks++;
      if (dac_data !== 16'h80FF) begin errors++; $display("FAIL slow_data: got %h expected 80ff", dac_data); end
      n_checks++;
      if (req_cnt != 8) begin errors++; $display("FAIL slow_req_cnt: got %0d expected 8", req_cnt); end
      resp_delay[3] = 1;
      cycles(2);
      $display("test_slow_voice done: dac_data=%h", dac_data);
   endtask

   task automatic test_overrun();
      bit ok;
      set_voices(16'h0100, 1);
      voice_mask = 8'hFF;
      dac_rdy    = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_start: got %b expected 0", overrun); end
      clear_log();
      tick();
      cycles(5);
      tick();
      n_checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_tick: got %b expected 1", overrun); end
      wait_done(ok);
      n_checks++;
      if (!ok || dac_data !== 16'h80FF || dac_vld !== 1'b1) begin
         errors++;
         $display("FAIL ovr_frame_a: got data %h vld %b expected 80ff vld 1", dac_data, dac_vld);
      end
      cycles(5);
      n_checks++;
      if (busy !== 1'b0 || req_cnt != 8) begin
         errors++;
         $display("FAIL ovr_dropped: got busy %b reqs %0d expected busy 0 reqs 8", busy, req_cnt);
      end
      set_voices(16'hFF00, 1);
      tick();
      wait_done(ok);
      n_checks++;
      if (!ok || dac_data !== 16'h7EFE || dac_vld !== 1'b1) begin
         errors++;
         $display("FAIL ovr_frame_b: got data %h vld %b expected 7efe vld 1", dac_data, dac_vld);
      end
      n_checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
`ifdef TDM_OVERRUN_COUNT_EN
      n_checks++;
      if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL ovr_cnt: got %0d expected 2", overrun_cnt); end
`endif
      cycles(3);
      n_checks++;
      if (dac_data !== 16'h7EFE || dac_vld !== 1'b1) begin
         errors++;
         $display("FAIL ovr_hold: got data %h vld %b expected 7efe vld 1", dac_data, dac_vld);
      end
      dac_rdy = 1'b1;
      cycles(1);
      n_checks++;
      if (dac_vld !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b expected 0", dac_vld); end
`ifdef TDM_OVERRUN_COUNT_EN
      overrun_clr = 1'b1;
      cycles(1);
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
         errors++;
         $display("FAIL ovr_clr: got %b/%0d expected 0/0", overrun, overrun_cnt);
      end
`endif
      $display("test_overrun done: overrun=%b", overrun);
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      set_voices(16'h0100, 1);
      resp_delay[2] = 30;
      voice_mask = 8'hFF;
      clear_log();
      tick();
      wait_req(2, ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL rst_req2: got no request expected idx 2"); end
      cycles(2);
      dsp_rst = 1'b1;
      cycles(1);
      n_checks++;
      if ({voice_req, voice_idx, pipe_chan, pipe_data, dac_data, dac_vld, busy, overrun} !== RESET_VEC) begin
         errors++;
         $display("FAIL rst_mid_values: got %h expected %h",
                  {voice_req, voice_idx, pipe_chan, pipe_data, dac_data, dac_vld, busy, overrun}, RESET_VEC);
      end
      dsp_rst = 1'b0;
      // Let the pending slow response expire while the scheduler idles.
      cycles(40);
      resp_delay[2] = 1;
      clear_log();
      tick();
      wait_done(ok);
      n_checks++;
      if (!ok) begin errors++; $display("FAIL rst_done: busy stuck at %b expected 0", busy); end
      n_checks++;
      if (dac_data !== 16'h80FF) begin errors++; $display("FAIL rst_data: got %h expected 80ff", dac_data); end
      n_checks++;
      if (req_cnt != 8) begin errors++; $display("FAIL rst_req_cnt: got %0d expected 8", req_cnt); end
      $display("test_reset_mid_frame done: dac_data=%h", dac_data);
   endtask

   initial begin
      dsp_rst     = 1'b1;
      sample_tick = 1'b0;
      voice_mask  = 8'hFF;
      dac_rdy     = 1'b1;
`ifdef TDM_OVERRUN_COUNT_EN
      overrun_clr = 1'b0;
`endif
      set_voices(16'h0100, 1);
      clear_log();
      test_reset();
      test_full_frame();
      test_masked();
      test_negative();
      test_slow_voice();
      test_overrun();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
